// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, cache frame layout
// and the helper that extracts a frame tag from a word address.
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int TAG_W  = 30;

  typedef enum logic [1:0] {
    IDLE,
    READ_MISS,
    WRITE,
    HALTED
  } dcache_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } dframe_t;

  // Tag is the word address with the index bits shifted out; unused upper bits stay zero.
  function automatic logic [TAG_W-1:0] tag_of(input logic [29:0] word_addr, input int idx_w);
    return word_addr >> idx_w;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Bundle of the pipeline-side request/response and memory-controller signals
// seen by the data-memory responder.
interface dmem_responder_if;

  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

endinterface

// File: rtl/dmem_responder_frame_array.sv
// Direct-mapped frame storage: one combinational read port, one write port,
// synchronous invalidate-all. Only valid bits are reset.
module dmem_responder_frame_array
  import dmem_responder_pkg::*;
#(
  parameter int SETS = 16,
  parameter int IDX  = $clog2(SETS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inval_all,
  input  logic [IDX-1:0] rd_idx,
  output dframe_t        rd_frame,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  dframe_t        wr_frame
);

  dframe_t frames [SETS];

  assign rd_frame = frames[rd_idx];

  always_ff @(posedge clk) begin
    if (rst || inval_all) begin
      for (int i = 0; i < SETS; i++) begin
        frames[i].valid <= 1'b0;
      end
    end else if (wr_en) begin
      frames[wr_idx] <= wr_frame;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Blocking direct-mapped, write-through, no-write-allocate data cache that
// answers EX/MEM requests and invalidates itself on halt.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int SETS = 16
) (
  input  logic             CLK,
  input  logic             RST,
  dmem_responder_if.slave  bus
);

  localparam int IDX = $clog2(SETS);

  dcache_state_t state;
  logic [29:0]   lat_word;
  logic [29:0]   cmp_word;
  logic [IDX-1:0] rd_idx;
  dframe_t       rd_frame;
  dframe_t       wr_frame;
  logic          wr_en;
  logic          tag_match;
  logic          inval_all;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.dmemaddr[1:0];
  assign bus.daddr        = {lat_word, 2'b00};
  assign inval_all        = (state == HALTED);

  // In IDLE the live request is looked up; otherwise the latched address owns the port.
  always_comb begin
    cmp_word  = (state == IDLE) ? bus.dmemaddr[31:2] : lat_word;
    rd_idx    = cmp_word[IDX-1:0];
    tag_match = rd_frame.valid && (rd_frame.tag == tag_of(cmp_word, IDX));
  end

  always_comb begin
    bus.dhit      = 1'b0;
    bus.dmemload  = '0;
    wr_en         = 1'b0;
    wr_frame.valid = 1'b1;
    wr_frame.tag   = tag_of(lat_word, IDX);
    wr_frame.data  = bus.dload;
    case (state)
      IDLE: begin
        if (!bus.dmemWEN && bus.dmemREN && tag_match) begin
          bus.dhit     = 1'b1;
          bus.dmemload = rd_frame.data;
        end
      end
      READ_MISS: begin
        if (!bus.dwait) begin
          bus.dhit     = 1'b1;
          bus.dmemload = bus.dload;
          wr_en        = 1'b1;
        end
      end
      WRITE: begin
        if (!bus.dwait) begin
          bus.dhit      = 1'b1;
          wr_en         = tag_match;
          wr_frame.data = bus.dstore;
        end
      end
      default: ;
    endcase
    if (RST) begin
      bus.dhit = 1'b0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      bus.dREN    <= 1'b0;
      bus.dWEN    <= 1'b0;
      bus.dstore  <= '0;
      bus.flushed <= 1'b0;
      lat_word    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dmemWEN) begin
            state      <= WRITE;
            bus.dWEN   <= 1'b1;
            lat_word   <= bus.dmemaddr[31:2];
            bus.dstore <= bus.dmemstore;
          end else if (bus.dmemREN && !tag_match) begin
            state    <= READ_MISS;
            bus.dREN <= 1'b1;
            lat_word <= bus.dmemaddr[31:2];
          end else if (!bus.dmemREN && bus.halt) begin
            state <= HALTED;
          end
        end
        READ_MISS: begin
          if (!bus.dwait) begin
            state    <= IDLE;
            bus.dREN <= 1'b0;
          end
        end
        WRITE: begin
          if (!bus.dwait) begin
            state    <= IDLE;
            bus.dWEN <= 1'b0;
          end
        end
        HALTED: bus.flushed <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_responder_frame_array #(.SETS(SETS), .IDX(IDX)) u_frames (
    .clk       (CLK),
    .rst       (RST),
    .inval_all (inval_all),
    .rd_idx    (rd_idx),
    .rd_frame  (rd_frame),
    .wr_en     (wr_en),
    .wr_idx    (lat_word[IDX-1:0]),
    .wr_frame  (wr_frame)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined datapath. It services the EX/MEM-stage data requests (`dmemREN`/`dmemWEN`, `dmemaddr`, `dmemstore`) and answers with `dhit`/`dmemload`, which the EX/MEM register consumes to release its stall. Internally it is a direct-mapped, write-through, no-write-allocate one-word-per-frame cache backed by the memory controller's `dREN`/`dWEN`/`dwait` port. On halt it invalidates its frames and reports `flushed`.

## Interface
- `SETS`, 16: number of frames, power of two ≥ 2; `IDX = log2(SETS)`.
- `CLK`  in  1  clock, all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `dmemREN`  in  1  load request from EX/MEM.
- `dmemWEN`  in  1  store request from EX/MEM.
- `dmemaddr`  in  32  byte address; `[1:0]` ignored.
- `dmemstore`  in  32  store data.
- `halt`  in  1  halt from EX/MEM.
- `dhit`  out  1  request complete this cycle.
- `dmemload`  out  32  load data, valid when `dhit && dmemREN`.
- `dREN`, `dWEN`  out  1  memory controller read/write strobes.
- `daddr`, `dstore`  out  32  memory controller address/data.
- `dwait`  in  1  memory controller busy; low = transfer done this cycle.
- `dload`  in  32  memory controller read data.
- `flushed`  out  1  sticky; halt processing complete.

## Operation
- Address split: index `dmemaddr[IDX+1:2]`, tag `dmemaddr[31:IDX+2]`. Each frame holds a valid bit, a tag, and a 32-bit data word.
- States: IDLE, READ_MISS, WRITE, HALTED.
- IDLE:
  - `dmemWEN` → latch addr/data, go to WRITE. `dmemWEN` has priority over `dmemREN` if both are high.
  - `dmemREN`, valid and tag match → `dhit=1` combinationally, `dmemload = frame.data`, stay in IDLE.
  - `dmemREN` miss → latch addr, go to READ_MISS.
  - `halt` with no request → go to HALTED.
- READ_MISS: `dREN=1`, `daddr = latched addr`. When `dwait=0`: `dhit=1` and `dmemload = dload` in the same cycle, fill the frame (valid, tag, data), return to IDLE.
- WRITE: `dWEN=1`, `daddr`/`dstore` from latches. When `dwait=0`: `dhit=1`. If the frame is valid with a matching tag, update its data to the store word (no allocate on miss). Return to IDLE.
- HALTED: clear all valid bits on entry. `flushed=1` from the cycle after entry until reset. Requests are ignored and `dhit=0`. Only `RST` exits this state.
- A transaction in flight always completes even if `dmemREN`/`dmemWEN` drop; the pipeline is required to hold the request until `dhit`.
- `halt` arriving during READ_MISS or WRITE is deferred until the return to IDLE.

## Timing
- Reset values: state IDLE, all valid bits 0, `dhit`/`dREN`/`dWEN`/`flushed` 0, `daddr`/`dstore`/`dmemload` 0.
- Read hit: 0-cycle latency, `dhit` in the request cycle.
- Miss or write: `dREN`/`dWEN` rises the cycle after the request. `dhit` occurs in the first cycle with `dwait=0`, so minimum latency is 1 cycle after the request.
- Back-to-back: a new request is evaluated in the IDLE cycle following `dhit`.
- `RST` mid-transaction: the next cycle has `dREN=dWEN=0`, state IDLE, cache invalid, and the pending request is dropped.
- A fill and a same-index hit never occur in the same cycle (blocking design).

## Structure
- Add to `cpu_types_pkg`: `dcache_state_t` enum (IDLE, READ_MISS, WRITE, HALTED) and `dframe_t` struct {valid, tag, data}.
- Sub-module `dcache_frame_array`: holds SETS × `dframe_t`, with one read port (combinational), one write port, and a synchronous invalidate-all.
- Top module: FSM, address/data latches, hit compare, output muxing.

## Test plan
- Cold load from 0x0000_0040 with `dwait` high for 3 cycles and `dload=0xDEAD_BEEF` → `dREN` high for 4 cycles; `dhit` with `dmemload=0xDEAD_BEEF` on the 4th; a repeat load hits the same cycle with no `dREN`.
- Store 0x1234_5678 to 0x40 after the fill → `dWEN` high with `daddr=0x40`, `dstore=0x1234_5678`; a subsequent load of 0x40 hits and returns 0x1234_5678.
- Store to uncached 0x80 → write completes and `dhit` fires; a load of 0x80 then misses (no allocate).
- Conflict: fill 0x40, then load 0x80 (same index when SETS=16) → miss; 0x80 replaces the frame; a reload of 0x40 misses.
- `halt` during a READ_MISS → the miss completes with `dhit`; HALTED is entered next; `flushed=1` one cycle later; a following load gives `dhit=0`.
- `RST` asserted mid-WRITE with `dwait=1` → next cycle `dWEN=0`, `flushed=0`, and a load of the previously cached address misses.
